// File: rtl/epu_pkg.sv
// Shared definitions for the encoder front end macroblock fetch path.
//   Y_WORDS / C_WORDS / MB_WORDS : words per luma plane, chroma plane, whole MB
//   fetch_state_t                : fetch sequencer states
//   plane_t                      : plane select for the unpack buffer
//   mb_y_t / mb_c_t              : luma 16x16 and chroma 8x8 pixel matrices
//   next_xy                      : raster-order coordinate step with wrap
package epu_pkg;

  localparam int Y_WORDS  = 64;
  localparam int C_WORDS  = 16;
  localparam int MB_WORDS = 96;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LD_Y = 3'd1,
    LD_U = 3'd2,
    LD_V = 3'd3,
    HOLD = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    PL_Y = 2'd0,
    PL_U = 2'd1,
    PL_V = 2'd2
  } plane_t;

  typedef logic [7:0] mb_y_t [16][16];
  typedef logic [7:0] mb_c_t [8][8];

  // Advance (x,y) in raster order; returns {y, x}. Wraps to (0,0) after the last MB.
  function automatic logic [11:0] next_xy(input logic [5:0] x, input logic [5:0] y,
                                          input logic [5:0] last_x, input logic [5:0] last_y);
    logic [5:0] nx;
    logic [5:0] ny;
    if (x == last_x) begin
      nx = 6'd0;
      ny = (y == last_y) ? 6'd0 : (y + 6'd1);
    end else begin
      nx = x + 6'd1;
      ny = y;
    end
    return {ny, nx};
  endfunction

endpackage

// File: rtl/mb_unpack_buf.sv
// One macroblock buffer: unpacks 32-bit frame-store words (byte0 = leftmost
// pixel) into the Y/U/V pixel matrices.
//   clk, rst : clock, asynchronous active-high reset (clears all pixels)
//   we       : write the word this cycle
//   plane    : target plane (Y, U or V)
//   widx     : word index within the plane (0..63 luma, 0..15 chroma)
//   word     : 4 packed pixels
//   mat_y/u/v: registered pixel matrices
module mb_unpack_buf
  import epu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  plane_t      plane,
  input  logic [5:0]  widx,
  input  logic [31:0] word,
  output mb_y_t       mat_y,
  output mb_c_t       mat_u,
  output mb_c_t       mat_v
);

  // Luma: 4 words per row; chroma: 2 words per row.
  logic [3:0] y_row;
  logic [3:0] y_col;
  logic [2:0] c_row;
  logic [2:0] c_col;

  assign y_row = widx[5:2];
  assign y_col = {widx[1:0], 2'b00};
  assign c_row = widx[3:1];
  assign c_col = {widx[0], 2'b00};

  // Pixel storage: scatter the four bytes of each accepted word into its row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          mat_y[r][c] <= 8'd0;
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          mat_u[r][c] <= 8'd0;
          mat_v[r][c] <= 8'd0;
        end
    end else if (we) begin
      case (plane)
        PL_Y: for (int b = 0; b < 4; b++) mat_y[y_row][y_col + 4'(b)] <= word[8*b +: 8];
        PL_U: for (int b = 0; b < 4; b++) mat_u[c_row][c_col + 3'(b)] <= word[8*b +: 8];
        PL_V: for (int b = 0; b < 4; b++) mat_v[c_row][c_col + 3'(b)] <= word[8*b +: 8];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mb_fetch_frame.sv
// Frame-level 4:2:0 macroblock fetch unit. Walks MB_COLS x MB_ROWS macroblocks
// in raster order, reading 96 contiguous words per MB starting at BASE_ADDR,
// and presents unpacked Y/U/V matrices over a valid/ready handshake.
//   fetch_start_i              : start one frame (only honoured in IDLE)
//   fetch_req_o / fetch_addr_o : word request and running word address
//   data_word_i / data_valid_i : returned word for fetch_addr_o
//   mb_valid_o / mb_ready_i    : MB handshake; mb_x_o/mb_y_o give its position
//   matrixY_o/U_o/V_o          : presented pixel matrices
//   frame_done_o               : one-cycle pulse after the last MB transfer
//   busy_o                     : not IDLE
// Build option FETCH_DOUBLE_BUF_EN: ping-pong buffers so loading of the next
// MB overlaps consumption of the current one. Undefined: single buffer with
// fetch and consume serialised through HOLD.
module mb_fetch_frame
  import epu_pkg::*;
#(
  parameter int                MB_COLS   = 22,
  parameter int                MB_ROWS   = 18,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start_i,
  output logic              fetch_req_o,
  output logic [ADDR_W-1:0] fetch_addr_o,
  input  logic [31:0]       data_word_i,
  input  logic              data_valid_i,
  output logic              mb_valid_o,
  input  logic              mb_ready_i,
  output logic [5:0]        mb_x_o,
  output logic [5:0]        mb_y_o,
  output mb_y_t             matrixY_o,
  output mb_c_t             matrixU_o,
  output mb_c_t             matrixV_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam logic [5:0] LAST_X = 6'(MB_COLS - 1);
  localparam logic [5:0] LAST_Y = 6'(MB_ROWS - 1);
  localparam logic [5:0] Y_LAST = 6'(Y_WORDS - 1);
  localparam logic [5:0] C_LAST = 6'(C_WORDS - 1);

  fetch_state_t state;
  fetch_state_t state_nxt;
  plane_t       plane;
  logic [5:0]   wcnt;
  logic         loading;
  logic         wr_en;
  logic         phase_end;
  logic         mb_end;
  logic         xfer;
  logic         pres_last;
  logic         frame_end;

  assign loading   = (state == LD_Y) || (state == LD_U) || (state == LD_V);
  assign wr_en     = loading && data_valid_i;
  assign phase_end = wr_en && (wcnt == ((state == LD_Y) ? Y_LAST : C_LAST));
  assign mb_end    = phase_end && (state == LD_V);
  assign xfer      = mb_valid_o && mb_ready_i;
  assign pres_last = (mb_x_o == LAST_X) && (mb_y_o == LAST_Y);
  assign frame_end = xfer && pres_last;

  assign fetch_req_o = loading;
  assign busy_o      = (state != IDLE);

  // Plane select follows the load phase.
  always_comb begin
    plane = PL_Y;
    case (state)
      LD_U:    plane = PL_U;
      LD_V:    plane = PL_V;
      default: plane = PL_Y;
    endcase
  end

`ifdef FETCH_DOUBLE_BUF_EN
  logic [1:0] full;
  logic       wr_sel;
  logic       rd_sel;
  logic       ld_done;
  logic       ld_last;
  logic       nxt_free;
  logic [5:0] ld_x;
  logic [5:0] ld_y;
  logic [5:0] bx [2];
  logic [5:0] by [2];
  mb_y_t      buf_y [2];
  mb_c_t      buf_u [2];
  mb_c_t      buf_v [2];

  assign ld_last  = (ld_x == LAST_X) && (ld_y == LAST_Y);
  // The buffer after the one being filled is usable if empty or drained this cycle.
  assign nxt_free = !full[~wr_sel] || (xfer && (rd_sel == ~wr_sel));

  for (genvar g = 0; g < 2; g++) begin : g_buf
    mb_unpack_buf u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en && (wr_sel == 1'(g))),
      .plane (plane),
      .widx  (wcnt),
      .word  (data_word_i),
      .mat_y (buf_y[g]),
      .mat_u (buf_u[g]),
      .mat_v (buf_v[g])
    );
  end

  assign mb_valid_o = full[rd_sel];
  assign mb_x_o     = bx[rd_sel];
  assign mb_y_o     = by[rd_sel];
  assign matrixY_o  = buf_y[rd_sel];
  assign matrixU_o  = buf_u[rd_sel];
  assign matrixV_o  = buf_v[rd_sel];

  // Buffer occupancy, ping-pong pointers and loader coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 2'b00;
      wr_sel  <= 1'b0;
      rd_sel  <= 1'b0;
      ld_done <= 1'b0;
      ld_x    <= 6'd0;
      ld_y    <= 6'd0;
      for (int i = 0; i < 2; i++) begin
        bx[i] <= 6'd0;
        by[i] <= 6'd0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (mb_end && (wr_sel == 1'(i)))
          full[i] <= 1'b1;
        else if (xfer && (rd_sel == 1'(i)))
          full[i] <= 1'b0;
      end
      if (xfer)
        rd_sel <= ~rd_sel;
      if (mb_end) begin
        wr_sel     <= ~wr_sel;
        bx[wr_sel] <= ld_x;
        by[wr_sel] <= ld_y;
        {ld_y, ld_x} <= next_xy(ld_x, ld_y, LAST_X, LAST_Y);
      end
      if (mb_end && ld_last)
        ld_done <= 1'b1;
      else if (frame_end)
        ld_done <= 1'b0;
    end
  end
`else
  mb_unpack_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .plane (plane),
    .widx  (wcnt),
    .word  (data_word_i),
    .mat_y (matrixY_o),
    .mat_u (matrixU_o),
    .mat_v (matrixV_o)
  );

  assign mb_valid_o = (state == HOLD);

  // Coordinates of the MB being loaded/presented; step on each transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mb_x_o <= 6'd0;
      mb_y_o <= 6'd0;
    end else if (xfer) begin
      {mb_y_o, mb_x_o} <= next_xy(mb_x_o, mb_y_o, LAST_X, LAST_Y);
    end
  end
`endif

  // Next-state logic for the fetch sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fetch_start_i) state_nxt = LD_Y; else state_nxt = IDLE;
      LD_Y: if (phase_end) state_nxt = LD_U; else state_nxt = LD_Y;
      LD_U: if (phase_end) state_nxt = LD_V; else state_nxt = LD_U;
`ifdef FETCH_DOUBLE_BUF_EN
      // HOLD doubles as loader stall (both buffers full) and end-of-frame drain.
      LD_V: begin
        if (mb_end && !ld_last && nxt_free) state_nxt = LD_Y;
        else if (mb_end)                    state_nxt = HOLD;
        else                                state_nxt = LD_V;
      end
      HOLD: begin
        if (ld_done)          state_nxt = frame_end ? IDLE : HOLD;
        else if (!full[wr_sel]) state_nxt = LD_Y;
        else                  state_nxt = HOLD;
      end
`else
      LD_V: if (mb_end) state_nxt = HOLD; else state_nxt = LD_V;
      HOLD: if (xfer) state_nxt = pres_last ? IDLE : LD_Y; else state_nxt = HOLD;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Word counter, running fetch address (reloads at frame end) and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt         <= 6'd0;
      fetch_addr_o <= BASE_ADDR;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= frame_end;
      if (wr_en)
        wcnt <= phase_end ? 6'd0 : (wcnt + 6'd1);
      if (frame_end)
        fetch_addr_o <= BASE_ADDR;
      else if (wr_en)
        fetch_addr_o <= fetch_addr_o + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mb_fetch_frame.sv
// Directed bench for mb_fetch_frame (default single-buffer build).
// Frame store model: word n (relative to the base) = {4n+3,4n+2,4n+1,4n} mod 256.
module tb_mb_fetch_frame;
  import epu_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam logic [31:0] BASE1 = 32'h0000_0040;

  logic        clk;
  logic        rst;
  logic        data_valid;
  logic        gap_en;
  int          n_vec;
  int          n_err;

  // 2x2 frame DUT
  logic        start;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] data_word;
  logic        mb_valid;
  logic        mb_ready;
  logic [5:0]  mb_x;
  logic [5:0]  mb_y;
  mb_y_t       mat_y;
  mb_c_t       mat_u;
  mb_c_t       mat_v;
  logic        frame_done;
  logic        busy;

  // 1x1 frame DUT
  logic        start1;
  logic        fetch_req1;
  logic [31:0] fetch_addr1;
  logic [31:0] data_word1;
  logic        mb_valid1;
  logic        mb_ready1;
  logic [5:0]  mb_x1;
  logic [5:0]  mb_y1;
  mb_y_t       mat_y1;
  mb_c_t       mat_u1;
  mb_c_t       mat_v1;
  logic        frame_done1;
  logic        busy1;

  function automatic logic [31:0] word_of(input logic [31:0] n);
    logic [7:0] b0;
    b0 = {n[5:0], 2'b00};
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  assign data_word  = word_of(fetch_addr - BASE);
  assign data_word1 = word_of(fetch_addr1 - BASE1);

  mb_fetch_frame #(.MB_COLS(2), .MB_ROWS(2), .ADDR_W(32), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst(rst), .fetch_start_i(start), .fetch_req_o(fetch_req),
    .fetch_addr_o(fetch_addr), .data_word_i(data_word), .data_valid_i(data_valid),
    .mb_valid_o(mb_valid), .mb_ready_i(mb_ready), .mb_x_o(mb_x), .mb_y_o(mb_y),
    .matrixY_o(mat_y), .matrixU_o(mat_u), .matrixV_o(mat_v),
    .frame_done_o(frame_done), .busy_o(busy)
  );

  mb_fetch_frame #(.MB_COLS(1), .MB_ROWS(1), .ADDR_W(32), .BASE_ADDR(BASE1)) u_dut1 (
    .clk(clk), .rst(rst), .fetch_start_i(start1), .fetch_req_o(fetch_req1),
    .fetch_addr_o(fetch_addr1), .data_word_i(data_word1), .data_valid_i(data_valid),
    .mb_valid_o(mb_valid1), .mb_ready_i(mb_ready1), .mb_x_o(mb_x1), .mb_y_o(mb_y1),
    .matrixY_o(mat_y1), .matrixU_o(mat_u1), .matrixV_o(mat_v1),
    .frame_done_o(frame_done1), .busy_o(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_valid changes just after the rising edge; random gaps when enabled
  initial begin
    data_valid = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      data_valid = gap_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Expected pixel of MB m (raster index in the 2x2 frame)
  function automatic int exp_y(input int m, input int r, input int c);
    return (128 * m + 16 * r + c) % 256;
  endfunction
  function automatic int exp_u(input int m, input int r, input int c);
    return (128 * m + 8 * r + c) % 256;
  endfunction
  function automatic int exp_v(input int m, input int r, input int c);
    return (128 * m + 64 + 8 * r + c) % 256;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_mb(input int m);
    int bad;
    bad = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (mat_y[r][c] !== 8'(exp_y(m, r, c))) bad++;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        if (mat_u[r][c] !== 8'(exp_u(m, r, c))) bad++;
        if (mat_v[r][c] !== 8'(exp_v(m, r, c))) bad++;
      end
    check($sformatf("mb%0d_x", m), mb_x, m % 2);
    check($sformatf("mb%0d_y", m), mb_y, m / 2);
    check($sformatf("mb%0d_Y00", m), mat_y[0][0], exp_y(m, 0, 0));
    check($sformatf("mb%0d_Y1515", m), mat_y[15][15], exp_y(m, 15, 15));
    check($sformatf("mb%0d_U77", m), mat_u[7][7], exp_u(m, 7, 7));
    check($sformatf("mb%0d_V00", m), mat_v[0][0], exp_v(m, 0, 0));
    check($sformatf("mb%0d_pix_bad", m), bad, 0);
  endtask

  // Called at a falling edge. One-cycle start pulse.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a falling edge with mb_ready high. Consumes a whole frame,
  // checks every MB, the address stepping and the done pulse.
  task automatic drain(input int n_mb, input bit start_on_done, input bit mid_start);
    int          idx;
    int          abad;
    bit          have_exp;
    bit          finished;
    logic [31:0] exp_a;
    idx = 0; abad = 0; have_exp = 1'b0; finished = 1'b0; exp_a = 32'd0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      start = 1'b0;
      if (have_exp && busy && fetch_addr !== exp_a) abad++;
      exp_a    = fetch_addr + ((data_valid && fetch_req) ? 32'd1 : 32'd0);
      have_exp = 1'b1;
      if (mid_start && busy && fetch_addr == BASE + 32'd150) start = 1'b1;
      if (mb_valid && mb_ready) begin
        check_mb(idx);
        idx++;
      end
      if (frame_done) begin
        finished = 1'b1;
        check("done_idle", busy, 0);
        check("done_addr_reload", fetch_addr, BASE);
        if (start_on_done) start = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("frame_finished", finished, 1);
    check("mb_count", idx, n_mb);
    check("addr_step_bad", abad, 0);
    check("done_single_pulse", frame_done, 0);
    if (start_on_done) begin
      check("b2b_busy", busy, 1);
      check("b2b_req", fetch_req, 1);
      check("b2b_addr", fetch_addr, BASE);
    end else begin
      check("post_idle", busy, 0);
    end
  endtask

  initial begin
    int          bad;
    logic [7:0]  snap_y;
    logic [7:0]  snap_v;
    n_vec = 0; n_err = 0;
    rst = 1'b1; gap_en = 1'b0;
    start = 1'b0; mb_ready = 1'b1;
    start1 = 1'b0; mb_ready1 = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_addr", fetch_addr, BASE);
    check("rst_busy", busy, 0);
    check("rst_req", fetch_req, 0);
    check("rst_valid", mb_valid, 0);
    check("rst_done", frame_done, 0);
    check("rst_Y00", mat_y[0][0], 0);
    check("rst_xy", {mb_y, mb_x}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Gap-free frame, then back-to-back start in the done cycle
    pulse_start();
    check("req_rise", fetch_req, 1);
    check("req_rise_addr", fetch_addr, BASE);
    drain(4, 1'b1, 1'b0);

    // Second frame with random valid gaps and an ignored mid-frame start
    gap_en = 1'b1;
    drain(4, 1'b0, 1'b1);
    gap_en = 1'b0;
    @(negedge clk);

    // Back-pressure: hold the first MB for 200 cycles
    pulse_start();
    for (int k = 0; k < 2000 && !mb_valid; k++) @(negedge clk);
    check("hold_valid_seen", mb_valid, 1);
    check_mb(0);
    mb_ready = 1'b0;
    snap_y = mat_y[3][7];
    snap_v = mat_v[5][2];
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!mb_valid || fetch_req || mat_y[3][7] !== snap_y || mat_v[5][2] !== snap_v ||
          mb_x !== 6'd0 || mb_y !== 6'd0 || fetch_addr !== BASE + 32'd96) bad++;
    end
    check("hold_stable_bad", bad, 0);
    check("hold_addr", fetch_addr, BASE + 32'd96);
    mb_ready = 1'b1;
    drain(4, 1'b0, 1'b0);

    // Reset at word 70 of MB0, then restart
    pulse_start();
    for (int k = 0; k < 2000 && fetch_addr !== BASE + 32'd70; k++) @(negedge clk);
    check("reach_word70", fetch_addr, BASE + 32'd70);
    check("partial_Y15", mat_y[1][5], 21);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_addr", fetch_addr, BASE);
    check("midrst_busy", busy, 0);
    check("midrst_req", fetch_req, 0);
    check("midrst_valid", mb_valid, 0);
    check("midrst_Y15", mat_y[1][5], 0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    drain(4, 1'b0, 1'b0);

    // 1x1 frame on the second instance
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("one_req", fetch_req1, 1);
    for (int k = 0; k < 500 && !mb_valid1; k++) @(negedge clk);
    check("one_valid", mb_valid1, 1);
    check("one_xy", {mb_y1, mb_x1}, 0);
    check("one_Y1515", mat_y1[15][15], 255);
    check("one_U77", mat_u1[7][7], 63);
    check("one_V00", mat_v1[0][0], 64);
    check("one_addr", fetch_addr1, BASE1 + 32'd96);
    mb_ready1 = 1'b1;
    @(negedge clk);
    mb_ready1 = 1'b0;
    check("one_done", frame_done1, 1);
    check("one_idle", busy1, 0);
    check("one_addr_reload", fetch_addr1, BASE1);
    @(negedge clk);
    check("one_done_pulse", frame_done1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mb_fetch_frame.md
# mb_fetch_frame

Parametrised frame-level macroblock fetch unit for the H.264 encoder front end. Walks an entire frame of 4:2:0 macroblocks in raster order, reading 96 32-bit words per MB (64 Y, 16 U, 16 V) from the frame store. Unpacks each MB into Y/U/V pixel matrices and hands them to the prediction/transform stage over a valid/ready handshake with back-pressure. Replaces the single-MB, fixed-position fetch used in bring-up.

## Interface
Parameters:
- MB_COLS, 22, macroblocks per row (1..64)
- MB_ROWS, 18, macroblock rows per frame (1..64)
- ADDR_W, 32, word-address width
- BASE_ADDR, 0, word address of MB(0,0) word 0

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; asynchronous, active-high
- fetch_start_i  in  1  pulse; starts one frame; ignored unless IDLE
- fetch_req_o  out  1  high while a word is being requested
- fetch_addr_o  out  ADDR_W  word address of the current request
- data_word_i  in  32  returned word; byte0 = leftmost pixel
- data_valid_i  in  1  data_word_i holds the word for fetch_addr_o this cycle
- mb_valid_o  out  1  matrices and coordinates valid
- mb_ready_i  in  1  consumer accepts; transfer when valid && ready
- mb_x_o, mb_y_o  out  6 each  coordinates of the presented MB
- matrixY_o  out  8b [16][16]  luma
- matrixU_o, matrixV_o  out  8b [8][8] each  chroma
- frame_done_o  out  1  one-cycle pulse after the last MB transfer
- busy_o  out  1  high whenever not IDLE

## Operation
- States: IDLE, LD_Y, LD_U, LD_V, HOLD.
- IDLE→LD_Y on fetch_start_i. LD_Y→LD_U after word 63; LD_U→LD_V after word 15; LD_V→HOLD after word 15 (non-double-buffered build). HOLD→LD_Y on transfer if MBs remain, else HOLD→IDLE.
- fetch_req_o = 1 in LD_*.
- fetch_addr_o is a running counter: +1 per data_valid_i, starting at BASE_ADDR. MBs are contiguous, so MB n word w = BASE_ADDR + 96n + w. Reloads BASE_ADDR at frame end. No multiplier.
- Word-to-pixel placement:
  - Y: word k goes to row k/4, columns 4(k%4)..+3.
  - U/V: word k goes to row k/2, columns 4(k%2)..+3.
- mb_x advances 0..MB_COLS-1 and wraps to 0 with mb_y+1. The last MB is (MB_COLS-1, MB_ROWS-1).
- data_valid_i outside LD_* is ignored.
- fetch_start_i while busy is ignored and does not restart the frame.

## Timing
- Reset values: all outputs 0, all matrices 0, fetch_addr_o = BASE_ADDR, state IDLE.
- Reset mid-frame: immediate return to reset values. No partial MB is presented.
- fetch_req_o rises the cycle after the fetch_start_i edge.
- Minimum MB load is 96 cycles with data_valid_i held high.
- mb_valid_o rises the cycle after the edge that captures V word 15.
- While mb_valid_o && !mb_ready_i, matrices, mb_x_o and mb_y_o are held stable.
- After a transfer, mb_valid_o drops next cycle unless another MB is already complete.
- frame_done_o pulses the cycle after the final transfer, coincident with the IDLE entry.
- A fetch_start_i arriving in that same cycle is accepted, giving back-to-back frames.

## Configuration
- FETCH_DOUBLE_BUF_EN defined:
  - Two ping-pong matrix buffers; LD_V→LD_Y of the next MB proceeds without waiting for the consumer.
  - The loader stalls (fetch_req_o = 0) only when both buffers are full.
  - Steady-state throughput is 96 cycles/MB with mb_ready_i held high.
  - Presented buffer and coordinates swap on transfer.
- Undefined: single buffer with the HOLD state as described. Fetch and consume serialise.

## Structure
- Shared package (epu_pkg):
  - Y_WORDS = 64, C_WORDS = 16, MB_WORDS = 96
  - fetch state enum
  - typedefs mb_y_t [16][16], mb_c_t [8][8]
- Sub-module mb_unpack_buf: one MB buffer with word index, plane select and write enable, unpacking 4 bytes per word. Instantiated once or twice depending on FETCH_DOUBLE_BUF_EN.

## Test plan
- MB_COLS = 2, MB_ROWS = 2, data_valid_i always high, mb_ready_i always high, word n = {4n+3,4n+2,4n+1,4n} mod 256 → 4 MBs at (0,0),(1,0),(0,1),(1,1).
  - MB1 Y[0][0] = 96·4 mod 256 = 128.
  - frame_done_o is a single pulse.
- Random data_valid_i gaps (50%) → pixel contents identical to the gap-free run; fetch_addr_o advances only on valid.
- mb_ready_i low for 200 cycles after the first mb_valid_o → outputs stable throughout.
  - Single-buffer build: fetch_req_o = 0 during the hold.
  - Double-buffer build: exactly one further MB loaded, then fetch_req_o = 0.
- rst asserted at word 70 of MB0, then restart → fetch_addr_o = BASE_ADDR and first presented MB is (0,0) with correct data.
- fetch_start_i pulsed mid-frame → ignored; fetch_start_i in the frame_done_o cycle → second frame starts at BASE_ADDR.
- MB_COLS = 1, MB_ROWS = 1 → one MB, frame_done_o pulses, then IDLE.
